// File: rtl/fft_frame_loader.sv
// Ping-pong input loader for the 64-point FFT: packs 64 complex samples per frame
// into flat Re/Im buses while the previously completed frame is held for the core.
module fft_frame_loader #(
  parameter int N_POINTS = 64,
  parameter int D_WIDTH  = 16,
  parameter int LOG2_N   = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [D_WIDTH-1:0]           in_re,
  input  logic [D_WIDTH-1:0]           in_im,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_POINTS*D_WIDTH-1:0]  out_re,
  output logic [N_POINTS*D_WIDTH-1:0]  out_im,
  output logic                         frame_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready and out_valid depend on registered state only.

  logic [D_WIDTH-1:0] mem_re [2][N_POINTS];
  logic [D_WIDTH-1:0] mem_im [2][N_POINTS];

  logic              wr_bank;
  logic              rd_bank;
  logic [LOG2_N-1:0] wr_idx;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              err_q;

  logic accept;
  logic at_end;
  logic complete;
  logic bad_frame;
  logic drain;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign frame_err = err_q;

  assign accept    = in_valid && in_ready;
  assign at_end    = (wr_idx == LOG2_N'(N_POINTS - 1));
  assign complete  = accept && at_end && in_last;
  assign bad_frame = accept && (at_end != in_last);
  assign drain     = out_valid && out_ready;

  // Completion needs !full[wr_bank] and drain needs full[rd_bank], so the two
  // updates always land on different banks.
  always_comb begin
    full_nxt = full;
    if (complete) full_nxt[wr_bank] = 1'b1;
    if (drain)    full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      full    <= '0;
      err_q   <= 1'b0;
    end else begin
      full  <= full_nxt;
      err_q <= bad_frame;
      if (complete) wr_bank <= !wr_bank;
      if (drain)    rd_bank <= !rd_bank;
      if (accept) begin
        // Good completion and both framing errors all restart at slot 0.
        if (in_last || at_end) wr_idx <= '0;
        else                   wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N_POINTS; k++) begin
          mem_re[b][k] <= '0;
          mem_im[b][k] <= '0;
        end
      end
    end else if (accept) begin
      mem_re[wr_bank][wr_idx] <= in_re;
      mem_im[wr_bank][wr_idx] <= in_im;
    end
  end

  // Presented frame comes straight from the storage flops of the read bank.
  always_comb begin
    out_re = '0;
    out_im = '0;
    for (int k = 0; k < N_POINTS; k++) begin
      out_re[k*D_WIDTH +: D_WIDTH] = mem_re[rd_bank][k];
      out_im[k*D_WIDTH +: D_WIDTH] = mem_im[rd_bank][k];
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: table of frame vectors, hand-written multi-cycle
// sequences, and a frame scoreboard fed at drive time and drained on handshakes.
module tb_fft_frame_loader;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int BW = N * DW;
  localparam int FW = 2 * BW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_re;
  logic [BW-1:0] out_im;
  logic          frame_err;

  fft_frame_loader #(.N_POINTS(N), .D_WIDTH(DW), .LOG2_N(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .frame_err (frame_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int exp_errs = 0;
  bit rand_ready = 1'b0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] hold;
  bit            hold_valid = 1'b0;
  bit            last_err = 1'b0;

  typedef struct {
    int len;
    int last_at;
    int base;
    bit exp_err;
    bit exp_frame;
  } vec_t;

  vec_t vecs[5];

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0b want %0b", name, got, want);
    end
  endtask

  task automatic check16(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_frame(input string name, input logic [FW-1:0] got, input logic [FW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      for (int s = 0; s < 2 * N; s++) begin
        if (got[s*DW +: DW] !== want[s*DW +: DW]) begin
          $display("FAIL %s %s slot %0d got %0h want %0h", name, (s < N) ? "re" : "im",
                   s % N, got[s*DW +: DW], want[s*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // driver tasks (main flow stays aligned to falling edges)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    while (!in_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got 0 want 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int len, input int last_at, input int base,
                            input bit rnd, input bit gaps, input bit chk_pre);
    logic [FW-1:0] f;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    bit good;
    good = (len == N) && (last_at == N - 1);
    f = '0;
    for (int k = 0; k < len; k++) begin
      if (rnd) begin
        re = DW'($urandom_range(0, 65535));
        im = DW'($urandom_range(0, 65535));
      end else begin
        re = DW'(base + k);
        im = DW'(-(base + k));
      end
      f[k*DW +: DW]      = re;
      f[BW + k*DW +: DW] = im;
      if (gaps && $urandom_range(0, 1) == 1) idle(1);
      if (k == len - 1) begin
        if (chk_pre) check_bit("pre_last_out_valid", out_valid, 1'b0);
        if (good) exp_q.push_back(f);
      end
      send(re, im, k == last_at);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
    @(negedge clk);
  endtask

  task automatic drain_wait();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
    end
  endtask

  // random downstream back-pressure, changed just after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // scoreboard / monitor, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_valid = 1'b0;
        last_err   = 1'b0;
      end else begin
        if (frame_err) begin
          err_seen++;
          check_bit("frame_err_single_pulse", last_err, 1'b0);
        end
        last_err = frame_err;
        if (out_valid) begin
          if (hold_valid) check_frame("hold_stable", {out_im, out_re}, hold);
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame got 1 want 0");
            end else begin
              check_frame("frame_data", {out_im, out_re}, exp_q.pop_front());
            end
            hold_valid = 1'b0;
          end else begin
            hold       = {out_im, out_re};
            hold_valid = 1'b1;
          end
        end else begin
          hold_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    vecs[0] = '{len: 64, last_at: 63, base: 0,   exp_err: 1'b0, exp_frame: 1'b1};
    vecs[1] = '{len: 11, last_at: 10, base: 0,   exp_err: 1'b1, exp_frame: 1'b0};
    vecs[2] = '{len: 64, last_at: 63, base: 200, exp_err: 1'b0, exp_frame: 1'b1};
    vecs[3] = '{len: 64, last_at: -1, base: 50,  exp_err: 1'b1, exp_frame: 1'b0};
    vecs[4] = '{len: 64, last_at: 63, base: 400, exp_err: 1'b0, exp_frame: 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_frame_err", frame_err, 1'b0);
    check_frame("reset_data", {out_im, out_re}, '0);
    idle(3);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // table of frames: good, early last, good, missing last, good
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].len, vecs[i].last_at, vecs[i].base, 1'b0, 1'b0, 1'b1);
      check_bit("vec_frame_err", frame_err, vecs[i].exp_err);
      check_bit("vec_out_valid", out_valid, vecs[i].exp_frame);
      if (vecs[i].exp_frame) check16("vec_slot0_re", out_re[DW-1:0], DW'(vecs[i].base));
      if (vecs[i].exp_err) exp_errs++;
      idle(1);
      check_bit("vec_frame_err_clear", frame_err, 1'b0);
      check_bit("vec_out_valid_drained", out_valid, 1'b0);
    end

    // two frames against a stalled consumer, then a single-cycle drain
    set_ready(1'b0);
    send_frame(64, 63, 0, 1'b0, 1'b0, 1'b0);
    send_frame(64, 63, 100, 1'b0, 1'b0, 1'b0);
    check_bit("both_full_in_ready", in_ready, 1'b0);
    check_bit("both_full_out_valid", out_valid, 1'b1);
    check16("both_full_slot0", out_re[DW-1:0], 16'd0);
    check16("both_full_slot63", out_re[63*DW +: DW], 16'd63);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_bit("after_drain_out_valid", out_valid, 1'b1);
    check16("after_drain_slot0", out_re[DW-1:0], 16'd100);
    check_bit("after_drain_in_ready", in_ready, 1'b1);
    set_ready(1'b1);
    drain_wait();

    // random gaps and random back-pressure over four frames
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(64, 63, 0, 1'b1, 1'b1, 1'b0);
    drain_wait();
    rand_ready = 1'b0;
    set_ready(1'b0);

    // asynchronous reset mid-frame with a full bank held
    send_frame(64, 63, 500, 1'b0, 1'b0, 1'b0);
    send_frame(30, -1, 600, 1'b0, 1'b0, 1'b0);
    check_bit("pre_reset_out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_rst_out_valid", out_valid, 1'b0);
    check_bit("async_rst_frame_err", frame_err, 1'b0);
    check_bit("async_rst_in_ready", in_ready, 1'b1);
    check_frame("async_rst_data", {out_im, out_re}, '0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_bit("post_rst_in_ready", in_ready, 1'b1);
    set_ready(1'b1);
    send_frame(64, 63, 300, 1'b0, 1'b0, 1'b1);
    check_bit("post_rst_out_valid", out_valid, 1'b1);
    check16("post_rst_slot0", out_re[DW-1:0], 16'd300);
    drain_wait();
    idle(2);

    checks++;
    if (err_seen != exp_errs) begin
      errors++;
      $display("FAIL frame_err_count got %0d want %0d", err_seen, exp_errs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Upstream input stage of the 64-point FFT datapath.
- Accepts complex samples one per handshake and packs each group of 64 into the flat 1024-bit Re/Im buses consumed by the bit-reversal input router.
- Ping-pong double buffered: a new frame streams in while the previous one is held for the FFT core.
- Samples stay in natural order; bit-reversal is done downstream.

Parameters:
N_POINTS, 64, samples per frame
D_WIDTH, 16, bits per real/imag component (signed two's complement)
LOG2_N, 6, width of sample index counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  sample present
in_ready  out  1  loader can accept sample
in_re  in  D_WIDTH  sample real part
in_im  in  D_WIDTH  sample imaginary part
in_last  in  1  marks final sample of frame
out_valid  out  1  complete frame presented
out_ready  in  1  downstream consumes frame
out_re  out  N_POINTS*D_WIDTH  frame real parts, sample k at [k*D_WIDTH +: D_WIDTH]
out_im  out  N_POINTS*D_WIDTH  frame imaginary parts, same packing
frame_err  out  1  one-cycle pulse: framing error, frame dropped

Behaviour:
- Reset (async assert, sync release): wr_bank=0, rd_bank=0, wr_idx=0, full[1:0]=0, both banks cleared to 0.
  - Outputs during reset: out_valid=0, out_re=out_im=0, frame_err=0, in_ready=1.
- Storage: two banks, each N_POINTS x 2 x D_WIDTH flops.
- Accept when in_valid && in_ready.
  - Write in_re/in_im into bank[wr_bank] slot wr_idx; wr_idx increments.
- in_ready = !full[wr_bank]. Combinational from registered state only; no dependence on in_valid.
- Frame completion: accept at wr_idx==N_POINTS-1 with in_last=1:
  - full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
- Framing errors (frame_err pulses high for exactly the cycle after the offending accept):
  - in_last=1 accepted at wr_idx<N_POINTS-1: frame dropped, wr_idx<=0, full unchanged, wr_bank unchanged.
  - in_last=0 accepted at wr_idx==N_POINTS-1: same drop behaviour.
  - Dropped bank contents may hold stale/partial data; never presented.
- Output side:
  - out_valid = full[rd_bank].
  - out_re/out_im = bank[rd_bank], driven straight from storage flops, no added register stage.
  - Data is stable while out_valid && !out_ready.
  - On out_valid && out_ready: full[rd_bank]<=0, rd_bank toggles.
- Latency: final sample accepted at edge T -> out_valid high after edge T (first cycle after T).
- Throughput: one sample per cycle sustained when downstream drains each frame within 64 cycles; no bubble between frames.
- Both banks full: in_ready=0 until a drain. in_ready rises the cycle after the drain edge if wr_bank is the drained bank.
- Simultaneous completion of the write bank and drain of the read bank in one cycle: both take effect. Banks differ, so no conflict.
- wr_bank==rd_bank with full set implies in_ready=0, so the presented bank is never overwritten.
- Frames are presented strictly in arrival order.
- in_valid may drop mid-frame; wr_idx holds. in_re/in_im ignored when not accepted.
- Reset mid-frame or with full banks: immediate clear of all state and data. The partial frame is lost; the next accepted sample is index 0.
- Index counter wraps via explicit reset to 0 only; no modulo aliasing past N_POINTS-1.

Test Plan:
1. Reset, stream 64 back-to-back samples re=k, im=-k, in_last on k=63, out_ready=1 -> out_valid high exactly 1 cycle after last accept; out_re[k*16+:16]=k, out_im=-k for all k; frame_err stays 0.
2. out_ready=0, stream 128 samples (two frames, frame1 re=100+k) -> in_ready drops after 128th accept; out shows frame0. Raise out_ready 1 cycle -> frame1 presented next cycle, in_ready=1 the cycle after the drain.
3. in_last asserted at k=10 -> frame_err single-cycle pulse, no out_valid. Following 64-sample frame re=200+k -> presented with slot0=200.
4. 64 samples with no in_last at k=63 -> frame_err pulse, no out_valid. Next correct frame is accepted normally.
5. Random in_valid gaps (50%) and random out_ready during 4 frames -> all frames delivered in order with correct data; no accept while in_ready=0; out data unchanged while out_valid && !out_ready.
6. Assert rst_n low asynchronously at sample 30 of frame1 while frame0 is full -> out_valid, out_re/out_im and frame_err go 0 without a clock edge. After release, in_ready=1; a fresh 64-sample frame is presented with slot0 = first post-reset sample.
